// File: rtl/mpu_frame_asm.sv
// MPU6050 sequencer and frame assembler: one-time init request, periodic burst-read launch,
// 14-byte collection into seven signed words with timeout abort and missed-tick accounting.
module mpu_frame_asm #(
    parameter int INIT_DELAY_CYC = 5_000_000,
    parameter int PERIOD_CYC     = 100_000,
    parameter int TIMEOUT_CYC    = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        busy_now,
    input  logic        data_avalid,
    input  logic [7:0]  data,
    output logic        mpu_init,
    output logic        mpu_transfer,
    output logic        init_done,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic [15:0] temp,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  missed_cnt
);

    localparam int DLY_W = (INIT_DELAY_CYC > 1) ? $clog2(INIT_DELAY_CYC) : 1;
    localparam int PER_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(INIT_DELAY_CYC - 1);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);
    localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [3:0]       IDX_LAST = 4'd13;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        INIT_WAIT,
        IDLE,
        COLLECT
    } state_t;

    state_t           state_reg, state_next;
    logic [DLY_W-1:0] dly_reg, dly_next;
    logic [1:0]       hold_reg, hold_next;
    logic [PER_W-1:0] per_reg, per_next;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic [3:0]       idx_reg, idx_next;
    logic             init_pulse_reg, init_pulse_next;
    logic             xfer_reg, xfer_next;
    logic             init_done_reg, init_done_next;
    logic             fv_reg, fv_next;
    logic             fe_reg, fe_next;
    logic [7:0]       missed_reg, missed_next;
    logic             run, tick, load_frame, store_byte;

    // Slots 0..12 are buffered; slot 13 is taken straight from the bus on the final byte.
    logic [7:0] byte_buf [16];

    always_comb begin
        state_next      = state_reg;
        dly_next        = dly_reg;
        hold_next       = hold_reg;
        per_next        = per_reg;
        tmo_next        = tmo_reg;
        idx_next        = idx_reg;
        init_pulse_next = 1'b0;
        xfer_next       = 1'b0;
        init_done_next  = init_done_reg;
        fv_next         = 1'b0;
        fe_next         = 1'b0;
        missed_next     = missed_reg;
        load_frame      = 1'b0;
        store_byte      = 1'b0;

        run  = (state_reg == IDLE) || (state_reg == COLLECT);
        tick = run && (per_reg == PER_LAST);

        if (run) begin
            per_next = tick ? '0 : per_reg + PER_ONE;
        end

        // A tick is lost if a frame is still in flight or the I2C master is busy.
        if (tick && ((state_reg == COLLECT) || busy_now) && (missed_reg != 8'hFF)) begin
            missed_next = missed_reg + 8'd1;
        end

        case (state_reg)
            PWR_WAIT: begin
                if (dly_reg == DLY_LAST) begin
                    state_next      = INIT;
                    init_pulse_next = 1'b1;
                end else begin
                    dly_next = dly_reg + DLY_ONE;
                end
            end
            INIT: begin
                state_next = INIT_WAIT;
                hold_next  = 2'd0;
            end
            INIT_WAIT: begin
                // The master needs a couple of cycles to raise busy after the request.
                if (hold_reg != 2'd2) begin
                    hold_next = hold_reg + 2'd1;
                end else if (!busy_now) begin
                    init_done_next = 1'b1;
                    per_next       = '0;
                    state_next     = IDLE;
                end
            end
            IDLE: begin
                if (tick && !busy_now) begin
                    xfer_next  = 1'b1;
                    idx_next   = 4'd0;
                    tmo_next   = '0;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (data_avalid) begin
                    tmo_next = '0;
                    if (idx_reg == IDX_LAST) begin
                        load_frame = 1'b1;
                        fv_next    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        store_byte = 1'b1;
                        idx_next   = idx_reg + 4'd1;
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    fe_next    = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo_reg + TMO_ONE;
                end
            end
            default: state_next = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= PWR_WAIT;
            dly_reg        <= '0;
            hold_reg       <= '0;
            per_reg        <= '0;
            tmo_reg        <= '0;
            idx_reg        <= '0;
            init_pulse_reg <= 1'b0;
            xfer_reg       <= 1'b0;
            init_done_reg  <= 1'b0;
            fv_reg         <= 1'b0;
            fe_reg         <= 1'b0;
            missed_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            dly_reg        <= dly_next;
            hold_reg       <= hold_next;
            per_reg        <= per_next;
            tmo_reg        <= tmo_next;
            idx_reg        <= idx_next;
            init_pulse_reg <= init_pulse_next;
            xfer_reg       <= xfer_next;
            init_done_reg  <= init_done_next;
            fv_reg         <= fv_next;
            fe_reg         <= fe_next;
            missed_reg     <= missed_next;
        end
    end

    always_ff @(posedge clk) begin
        if (store_byte) begin
            byte_buf[idx_reg] <= data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_word
            logic [15:0] word_reg;
            logic [7:0]  lo_byte;
            if (gi == 6) begin : g_last
                assign lo_byte = data;
            end else begin : g_buf
                assign lo_byte = byte_buf[2*gi+1];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (load_frame) begin
                    word_reg <= {byte_buf[2*gi], lo_byte};
                end
            end
        end
    endgenerate

    assign accel_x      = g_word[0].word_reg;
    assign accel_y      = g_word[1].word_reg;
    assign accel_z      = g_word[2].word_reg;
    assign temp         = g_word[3].word_reg;
    assign gyro_x       = g_word[4].word_reg;
    assign gyro_y       = g_word[5].word_reg;
    assign gyro_z       = g_word[6].word_reg;
    assign mpu_init     = init_pulse_reg;
    assign mpu_transfer = xfer_reg;
    assign init_done    = init_done_reg;
    assign frame_valid  = fv_reg;
    assign frame_err    = fe_reg;
    assign missed_cnt   = missed_reg;

endmodule

// File: tb/tb_mpu_frame_asm.sv
// Randomized bench for mpu_frame_asm: expected words, pulse timing and missed counts are
// derived from the byte stream and launch schedule held in the bench.
module tb_mpu_frame_asm;

    localparam int D = 10;
    localparam int P = 200;
    localparam int T = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy_now = 1'b1;
    logic        data_avalid = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        mpu_init, mpu_transfer, init_done, frame_valid, frame_err;
    logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
    logic [7:0]  missed_cnt;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          init_cnt = 0;
    int          ovl_cnt = 0;
    int          next_launch = 0;
    logic [7:0]  fb [14];
    logic [15:0] exp_w [7];

    mpu_frame_asm #(
        .INIT_DELAY_CYC(D),
        .PERIOD_CYC    (P),
        .TIMEOUT_CYC   (T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .busy_now    (busy_now),
        .data_avalid (data_avalid),
        .data        (data),
        .mpu_init    (mpu_init),
        .mpu_transfer(mpu_transfer),
        .init_done   (init_done),
        .accel_x     (accel_x),
        .accel_y     (accel_y),
        .accel_z     (accel_z),
        .temp        (temp),
        .gyro_x      (gyro_x),
        .gyro_y      (gyro_y),
        .gyro_z      (gyro_z),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .missed_cnt  (missed_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mpu_init) init_cnt++;
        if ((mpu_init && mpu_transfer) || (frame_valid && frame_err)) ovl_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] dut_word(input int k);
        case (k)
            0: return accel_x;
            1: return accel_y;
            2: return accel_z;
            3: return temp;
            4: return gyro_x;
            5: return gyro_y;
            default: return gyro_z;
        endcase
    endfunction

    task automatic check_words(input string tag);
        for (int k = 0; k < 7; k++)
            chk($sformatf("%s_w%0d", tag, k), 32'(dut_word(k)), 32'(exp_w[k]));
    endtask

    task automatic wait_xfer(input string tag, input int exp_cyc);
        int n = 0;
        while (!mpu_transfer && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_xfer_seen"}, 32'(mpu_transfer), 32'd1);
        chk({tag, "_xfer_cyc"}, 32'(cyc), 32'(exp_cyc));
        next_launch = cyc + P;
        @(negedge clk);
        chk({tag, "_xfer_width"}, 32'(mpu_transfer), 32'd0);
    endtask

    task automatic send_bytes(input int nbytes, input int gap, input bit rand_busy);
        for (int i = 0; i < nbytes; i++) begin
            for (int j = 0; j < gap - 1; j++) begin
                if (rand_busy) busy_now = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            data        = fb[i];
            data_avalid = 1'b1;
            @(negedge clk);
            data_avalid = 1'b0;
            data        = 8'($urandom);
        end
        busy_now = 1'b0;
    endtask

    task automatic rand_fill();
        for (int i = 0; i < 14; i++) fb[i] = 8'($urandom);
    endtask

    task automatic run_frame(input string tag, input int gap);
        wait_xfer(tag, next_launch);
        send_bytes(14, gap, 1'b1);
        for (int k = 0; k < 7; k++) exp_w[k] = {fb[2*k], fb[2*k+1]};
        chk({tag, "_fv"}, 32'(frame_valid), 32'd1);
        chk({tag, "_fe"}, 32'(frame_err), 32'd0);
        check_words(tag);
        $display("frame %s gap=%0d ax=%h ay=%h az=%h t=%h gx=%h gy=%h gz=%h missed=%0d",
                 tag, gap, accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z, missed_cnt);
        @(negedge clk);
        chk({tag, "_fv_width"}, 32'(frame_valid), 32'd0);
    endtask

    initial begin
        int  rel, bf, b5, n;
        bit  saw;
        for (int k = 0; k < 7; k++) exp_w[k] = 16'h0;

        repeat (3) @(negedge clk);
        chk("rst_init", 32'(mpu_init), 32'd0);
        chk("rst_xfer", 32'(mpu_transfer), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_missed", 32'(missed_cnt), 32'd0);
        check_words("rst");

        rst_n = 1'b1;
        rel   = cyc;
        n     = 0;
        while (!mpu_init && n < 100) begin @(negedge clk); n++; end
        chk("init_seen", 32'(mpu_init), 32'd1);
        chk("init_delay", 32'(cyc - rel), 32'(D));
        $display("init pulse at %0d cycles after release", cyc - rel);

        repeat (30) @(negedge clk);
        chk("init_done_held", 32'(init_done), 32'd0);
        busy_now = 1'b0;
        bf = cyc;
        n  = 0;
        while (!init_done && n < 100) begin @(negedge clk); n++; end
        chk("init_done_seen", 32'(init_done), 32'd1);
        chk("init_done_cyc", 32'(cyc - bf), 32'd1);
        next_launch = cyc + P;

        for (int i = 0; i < 14; i++) fb[i] = 8'(i + 1);
        run_frame("good", 8);
        chk("good_ax", 32'(accel_x), 32'h0102);
        chk("good_temp", 32'(temp), 32'h0708);
        chk("good_gz", 32'(gyro_z), 32'h0D0E);

        rand_fill();
        fb[0] = 8'hFF;
        fb[1] = 8'h38;
        run_frame("sign", $urandom_range(1, 12));
        chk("sign_ax", 32'($signed(accel_x)), 32'(-200));

        for (int r = 0; r < 3; r++) begin
            rand_fill();
            run_frame($sformatf("rand%0d", r), $urandom_range(1, 12));
        end

        wait_xfer("tmo", next_launch);
        rand_fill();
        send_bytes(5, 6, 1'b0);
        b5 = cyc;
        n  = 0;
        while (!frame_err && n < 200) begin @(negedge clk); n++; end
        chk("tmo_seen", 32'(frame_err), 32'd1);
        chk("tmo_cyc", 32'(cyc - b5), 32'(T));
        chk("tmo_fv", 32'(frame_valid), 32'd0);
        check_words("tmo_hold");
        $display("timeout frame_err %0d cycles after byte 5", cyc - b5);
        @(negedge clk);
        chk("tmo_width", 32'(frame_err), 32'd0);

        rand_fill();
        run_frame("after_tmo", 5);

        busy_now = 1'b1;
        saw = 1'b0;
        while (cyc < next_launch + 2) begin
            @(negedge clk);
            if (mpu_transfer) saw = 1'b1;
        end
        chk("miss_no_xfer", 32'(saw), 32'd0);
        chk("miss_cnt1", 32'(missed_cnt), 32'd1);
        $display("missed tick in idle, missed=%0d", missed_cnt);
        busy_now = 1'b0;
        next_launch += P;
        rand_fill();
        run_frame("after_miss", 4);

        rand_fill();
        run_frame("span", 20);
        chk("miss_cnt2", 32'(missed_cnt), 32'd2);
        next_launch += P;
        rand_fill();
        run_frame("after_span", 3);

        wait_xfer("midrst", next_launch);
        rand_fill();
        send_bytes(7, 4, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 7; k++) exp_w[k] = 16'h0;
        chk("midrst_init_done", 32'(init_done), 32'd0);
        chk("midrst_missed", 32'(missed_cnt), 32'd0);
        chk("midrst_xfer", 32'(mpu_transfer), 32'd0);
        chk("midrst_fv", 32'(frame_valid), 32'd0);
        check_words("midrst");
        $display("mid-frame reset applied after 7 bytes");
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        n     = 0;
        while (!mpu_init && n < 100) begin @(negedge clk); n++; end
        chk("reinit_seen", 32'(mpu_init), 32'd1);
        chk("reinit_delay", 32'(cyc - rel), 32'(D));
        @(negedge clk);
        chk("init_pulse_count", 32'(init_cnt), 32'd2);
        chk("pulse_overlap", 32'(ovl_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mpu_frame_asm.md
# mpu_frame_asm

Sequencer and frame assembler for the MPU6050 path, sitting directly downstream of the bit-banged I2C master. After power-up it issues the one-time `mpu_init` request, then fires `mpu_transfer` at a fixed sample rate. It collects the 14-byte burst read (0x3B..0x48) from `data`/`data_avalid` and publishes seven signed 16-bit words with a one-cycle `frame_valid` strobe. It feeds the attitude-estimation logic.

## Interface
- `INIT_DELAY_CYC`, 5_000_000: cycles from reset release to the `mpu_init` pulse (100 ms at 50 MHz).
- `PERIOD_CYC`, 100_000: sample period in cycles (500 Hz at 50 MHz). Must be ≥ 2.
- `TIMEOUT_CYC`, 50_000: maximum gap between bytes, and between `mpu_transfer` and the first byte, before a frame is aborted.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `busy_now` in 1: I2C master busy.
- `data_avalid` in 1: one-cycle strobe per received byte.
- `data` in 8: received byte, valid while `data_avalid` = 1.
- `mpu_init` out 1: one-cycle request to run the MPU register init sequence.
- `mpu_transfer` out 1: one-cycle request for the 14-byte burst read.
- `init_done` out 1: sticky; set once the init transaction completes.
- `accel_x`, `accel_y`, `accel_z`, `temp`, `gyro_x`, `gyro_y`, `gyro_z` out 16 each: signed words of the last good frame.
- `frame_valid` out 1: one-cycle strobe; all seven words updated.
- `frame_err` out 1: one-cycle strobe; the frame was aborted on timeout.
- `missed_cnt` out 8: saturating count of sample ticks that could not launch a transfer.

## Operation
- **States:** PWR_WAIT → INIT → INIT_WAIT → IDLE ⇄ COLLECT.
- **PWR_WAIT:** the delay counter counts 0..`INIT_DELAY_CYC`-1. At terminal count, go to INIT.
- **INIT:** `mpu_init` = 1 for exactly this one cycle, then go to INIT_WAIT.
- **INIT_WAIT:** ignore `busy_now` for the first 2 cycles. After that, the first cycle with `busy_now` = 0 sets `init_done` and moves to IDLE. In the same transition the period counter is cleared to 0 and starts running.
- **Period counter:**
  - Free-running 0..`PERIOD_CYC`-1 in IDLE and COLLECT.
  - The tick is the cycle in which the counter equals `PERIOD_CYC`-1.
- **IDLE:**
  - Tick with `busy_now` = 0: `mpu_transfer` = 1 next cycle, byte index ← 0, timeout counter ← 0, go to COLLECT.
  - Tick with `busy_now` = 1: `missed_cnt` += 1, stay in IDLE.
- **COLLECT:**
  - Each cycle with `data_avalid` = 1 stores `data` into byte slot `idx`, increments `idx`, and clears the timeout counter.
  - Slot order: AXH AXL AYH AYL AZH AZL TH TL GXH GXL GYH GYL GZH GZL. Each word = {H, L}, two's complement, passed through unchanged.
  - On the byte with `idx` = 13:
    - all seven outputs load simultaneously from the slot buffer plus this byte;
    - `frame_valid` = 1 on the same edge;
    - go to IDLE.
  - A tick while in COLLECT increments `missed_cnt`. It does not abort the frame and is not queued.
  - Timeout counter reaches `TIMEOUT_CYC`-1 with no byte: `frame_err` = 1 for one cycle, partial bytes discarded, outputs hold previous values, go to IDLE.
  - If timeout and `data_avalid` occur in the same cycle, the byte wins and the counter clears.
- **Ignored inputs:**
  - `data_avalid` outside COLLECT is ignored.
  - `busy_now` is ignored in COLLECT.
- **`missed_cnt`:** saturates at 255 and clears only on reset.
- **Reset (any time, including mid-frame):**
  - all outputs = 0, `init_done` = 0;
  - state = PWR_WAIT, all counters and `idx` = 0;
  - the full init sequence repeats after reset release.

## Timing
- `mpu_init` and `mpu_transfer` are registered single-cycle pulses and never overlap.
- `mpu_transfer` is high in the cycle after the tick.
- The first `mpu_transfer` comes `PERIOD_CYC` cycles after `init_done` rises.
- Frame latency: output words and `frame_valid` change on the rising edge that samples the 14th `data_avalid`. They are visible in the following cycle.
- Launch spacing is exactly `PERIOD_CYC` cycles whenever no tick is missed.
- `frame_valid` and `frame_err` are mutually exclusive.
- Counter widths are `$clog2` of their parameter (minimum 1).

## Test plan
Bench parameters: `INIT_DELAY_CYC`=10, `PERIOD_CYC`=200, `TIMEOUT_CYC`=50.

- **Reset release:** `mpu_init` pulses once, 10 cycles after `rst_n` rises. Model holds `busy_now` high for 30 cycles → `init_done` = 1 once `busy_now` falls. The first `mpu_transfer` follows 200 cycles later.
- **Good frame:** model returns bytes 0x01..0x0E, one every 8 cycles → `accel_x`=0x0102, `temp`=0x0708, `gyro_z`=0x0D0E. `frame_valid` is a 1-cycle pulse the cycle after byte 14.
- **Sign:** bytes 0xFF,0x38 in the AX slots → `accel_x` = -200 (0xFF38).
- **Timeout:** send 5 bytes then stop → `frame_err` pulses 50 cycles after the 5th byte. Outputs retain the prior frame, and the next transfer launches on the next tick.
- **Missed tick:** hold `busy_now` = 1 across a tick in IDLE → no `mpu_transfer`, `missed_cnt` = 1. A frame that spans a tick completes normally and `missed_cnt` increments.
- **Mid-frame reset:** assert `rst_n` = 0 after byte 7 → all outputs 0 immediately. On release, `mpu_init` re-issues after 10 cycles.
